// File: rtl/branch_resolver_if.sv
// Bundles the decode-push, execute-resolve and predictor-feedback signals
// of the branch resolver into a single port.
// master: pipeline side (decode/execute/predictor); slave: the resolver.
interface branch_resolver_if #(
  parameter int ADDR_SIZE = 32
);
  logic                 push;
  logic [ADDR_SIZE-1:0] push_pc;
  logic                 push_opinion;
  logic                 push_taken;
  logic [ADDR_SIZE-1:0] push_addr;
  logic                 full;
  logic                 empty;
  logic                 resolve;
  logic                 resolve_taken;
  logic [ADDR_SIZE-1:0] resolve_target;
  logic                 feedback_enable;
  logic                 feedback_branch_taken;
  logic [ADDR_SIZE-1:0] feedback_branch_addr;
  logic [ADDR_SIZE-1:0] feedback_current_pc;
  logic                 mispredict;
  logic [ADDR_SIZE-1:0] redirect_pc;
  logic                 underflow;
  logic [31:0]          stat_branches;
  logic [31:0]          stat_mispredicts;

  modport master (
    output push, push_pc, push_opinion, push_taken, push_addr,
    output resolve, resolve_taken, resolve_target,
    input  full, empty, feedback_enable, feedback_branch_taken,
    input  feedback_branch_addr, feedback_current_pc, mispredict,
    input  redirect_pc, underflow, stat_branches, stat_mispredicts
  );

  modport slave (
    input  push, push_pc, push_opinion, push_taken, push_addr,
    input  resolve, resolve_taken, resolve_target,
    output full, empty, feedback_enable, feedback_branch_taken,
    output feedback_branch_addr, feedback_current_pc, mispredict,
    output redirect_pc, underflow, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: in-order FIFO of branch predictions from decode. When
// execute resolves the oldest branch, the actual next PC is compared with
// the predicted one; a registered predictor update and a redirect/flush
// pulse are produced one cycle later. A mispredict discards all younger
// (wrong-path) entries.
// Optional feature macro: BRANCH_STATS_EN adds saturating branch and
// mispredict counters; without it the stat outputs are tied to 0.
module branch_resolver #(
  parameter int ADDR_SIZE = 32,
  parameter int DEPTH_LOG = 2
) (
  input  logic              clk,
  input  logic              reset,
  branch_resolver_if.slave  bus
);

  localparam int                   LP_DEPTH      = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0]   LP_FULL_COUNT = {1'b1, {DEPTH_LOG{1'b0}}};
  localparam logic [DEPTH_LOG:0]   LP_COUNT_ONE  = (DEPTH_LOG+1)'(1);
  localparam logic [DEPTH_LOG-1:0] LP_PTR_ONE    = DEPTH_LOG'(1);
  localparam logic [ADDR_SIZE-1:0] LP_STEP       = ADDR_SIZE'(4);

  // Prediction storage, one slot per in-flight branch
  logic [ADDR_SIZE-1:0] r_pcMem      [LP_DEPTH];
  logic                 r_opinionMem [LP_DEPTH];
  logic                 r_takenMem   [LP_DEPTH];
  logic [ADDR_SIZE-1:0] r_addrMem    [LP_DEPTH];

  logic [DEPTH_LOG-1:0] r_rdPtr;
  logic [DEPTH_LOG-1:0] r_wrPtr;
  logic [DEPTH_LOG:0]   r_count;

  logic                 r_fbEnable;
  logic                 r_fbTaken;
  logic [ADDR_SIZE-1:0] r_fbAddr;
  logic [ADDR_SIZE-1:0] r_fbPc;
  logic                 r_mispredict;
  logic [ADDR_SIZE-1:0] r_redirectPc;
  logic                 r_underflow;

  logic                 w_notEmpty;
  logic                 w_isFull;
  logic [ADDR_SIZE-1:0] w_headPc;
  logic                 w_headOpinion;
  logic                 w_headTaken;
  logic [ADDR_SIZE-1:0] w_headAddr;
  logic [ADDR_SIZE-1:0] w_fallThrough;
  logic [ADDR_SIZE-1:0] w_predNext;
  logic [ADDR_SIZE-1:0] w_actNext;
  logic                 w_pop;
  logic                 w_flush;
  logic                 w_pushOk;
  logic [DEPTH_LOG-1:0] w_rdPtrNext;
  logic [DEPTH_LOG:0]   w_countNext;

  assign w_notEmpty    = (r_count != '0);
  assign w_isFull      = (r_count == LP_FULL_COUNT);
  assign w_headPc      = r_pcMem[r_rdPtr];
  assign w_headOpinion = r_opinionMem[r_rdPtr];
  assign w_headTaken   = r_takenMem[r_rdPtr];
  assign w_headAddr    = r_addrMem[r_rdPtr];
  assign w_fallThrough = w_headPc + LP_STEP;
  assign w_predNext    = (w_headOpinion && w_headTaken) ? w_headAddr : w_fallThrough;
  assign w_actNext     = bus.resolve_taken ? bus.resolve_target : w_fallThrough;
  assign w_pop         = bus.resolve && w_notEmpty;
  assign w_flush       = w_pop && (w_predNext != w_actNext);
  // Younger pushes are wrong-path during a mispredict; a full FIFO only
  // accepts when the head leaves in the same cycle.
  assign w_pushOk      = bus.push && !r_mispredict && !w_flush && (!w_isFull || w_pop);
  assign w_rdPtrNext   = r_rdPtr + LP_PTR_ONE;

  // Next occupancy: flush empties, otherwise push and pop cancel
  always_comb begin
    w_countNext = r_count;
    if (w_flush) begin
      w_countNext = '0;
    end else if (w_pushOk && !w_pop) begin
      w_countNext = r_count + LP_COUNT_ONE;
    end else if (!w_pushOk && w_pop) begin
      w_countNext = r_count - LP_COUNT_ONE;
    end
  end

  // Record accepted predictions at the write pointer
  always_ff @(posedge clk) begin
    if (w_pushOk) begin
      r_pcMem[r_wrPtr]      <= bus.push_pc;
      r_opinionMem[r_wrPtr] <= bus.push_opinion;
      r_takenMem[r_wrPtr]   <= bus.push_taken;
      r_addrMem[r_wrPtr]    <= bus.push_addr;
    end
  end

  // FIFO pointers, registered feedback/redirect and sticky underflow
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdPtr      <= '0;
      r_wrPtr      <= '0;
      r_count      <= '0;
      r_fbEnable   <= 1'b0;
      r_fbTaken    <= 1'b0;
      r_fbAddr     <= '0;
      r_fbPc       <= '0;
      r_mispredict <= 1'b0;
      r_redirectPc <= '0;
      r_underflow  <= 1'b0;
    end else begin
      r_count      <= w_countNext;
      r_fbEnable   <= w_pop;
      r_mispredict <= w_flush;
      if (w_pop) begin
        r_rdPtr      <= w_rdPtrNext;
        r_fbTaken    <= bus.resolve_taken;
        r_fbAddr     <= bus.resolve_target;
        r_fbPc       <= w_headPc;
        r_redirectPc <= w_actNext;
      end
      if (w_flush) begin
        r_wrPtr <= w_rdPtrNext;
      end else if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + LP_PTR_ONE;
      end
      if (bus.resolve && !w_notEmpty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign bus.full                  = w_isFull;
  assign bus.empty                 = !w_notEmpty;
  assign bus.feedback_enable       = r_fbEnable;
  assign bus.feedback_branch_taken = r_fbTaken;
  assign bus.feedback_branch_addr  = r_fbAddr;
  assign bus.feedback_current_pc   = r_fbPc;
  assign bus.mispredict            = r_mispredict;
  assign bus.redirect_pc           = r_redirectPc;
  assign bus.underflow             = r_underflow;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_statBranches;
  logic [31:0] r_statMispredicts;

  // Saturating counts of resolved branches and mispredicts
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_statBranches    <= '0;
      r_statMispredicts <= '0;
    end else begin
      if (w_pop && (r_statBranches != '1)) begin
        r_statBranches <= r_statBranches + 32'd1;
      end
      if (w_flush && (r_statMispredicts != '1)) begin
        r_statMispredicts <= r_statMispredicts + 32'd1;
      end
    end
  end

  assign bus.stat_branches    = r_statBranches;
  assign bus.stat_mispredicts = r_statMispredicts;
`else
  assign bus.stat_branches    = 32'd0;
  assign bus.stat_mispredicts = 32'd0;
`endif

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Tracks branch predictions from decode to execute and closes the loop back to the branch predictor. Decode pushes each branch's prediction into an in-order FIFO; when execute resolves the oldest branch, the block compares the actual next PC with the predicted one. It then issues a registered update on the predictor's feedback port, plus a mispredict/redirect pulse to fetch. On a mispredict, all younger (wrong-path) entries are discarded.

## Interface
Parameters:
- ADDR_SIZE, 32, PC/address width in bits
- DEPTH_LOG, 2, FIFO holds 2^DEPTH_LOG in-flight branches

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- push  in  1  decode has a branch; record its prediction
- push_pc  in  ADDR_SIZE  branch PC
- push_opinion  in  1  predictor had a valid entry for push_pc
- push_taken  in  1  predictor's taken bit
- push_addr  in  ADDR_SIZE  predictor's target
- full  out  1  FIFO holds 2^DEPTH_LOG entries (combinational from count)
- empty  out  1  FIFO holds 0 entries
- resolve  in  1  execute resolves the oldest in-flight branch
- resolve_taken  in  1  actual outcome
- resolve_target  in  ADDR_SIZE  actual taken target
- feedback_enable  out  1  one-cycle predictor update strobe
- feedback_branch_taken  out  1  actual outcome
- feedback_branch_addr  out  ADDR_SIZE  resolve_target
- feedback_current_pc  out  ADDR_SIZE  PC of the resolved branch
- mispredict  out  1  one-cycle redirect/flush pulse
- redirect_pc  out  ADDR_SIZE  correct next PC
- underflow  out  1  sticky; resolve seen while empty
- stat_branches, stat_mispredicts  out  32  counters (see Configuration)

## Operation
- FIFO: circular buffer, DEPTH_LOG-bit read/write pointers, (DEPTH_LOG+1)-bit count; pointers wrap modulo 2^DEPTH_LOG.
- Entry = {pc, opinion, taken, addr}.
- Predicted next PC = (opinion && taken) ? addr : pc+4.
- Actual next PC = resolve_taken ? resolve_target : pc+4.
- All +4 arithmetic is modulo 2^ADDR_SIZE.
- On resolve with FIFO non-empty (head entry):
  - pop the head;
  - drive feedback_* from the head entry and resolve inputs;
  - assert mispredict iff predicted next PC != actual next PC;
  - redirect_pc = actual next PC.
- Mispredict flush: at the same edge as the pop, count goes to 0 and the write pointer is set to the new read pointer.
- Push in the same cycle as a mispredicting resolve is discarded (it is a younger instruction).
- Push while mispredict output is high is discarded (wrong-path decode).
- Push while full: accepted only if resolve pops in the same cycle without mispredict; otherwise dropped. Upstream must stall on full.
- Resolve while empty: ignored, no feedback, no mispredict; sets underflow, which stays set until reset.
- Simultaneous push and non-mispredicting resolve: both take effect; count unchanged.

## Timing
- Reset (reset=0 at an edge) values: all outputs 0 except empty=1; pointers and count 0; underflow cleared.
- Reset mid-operation discards in-flight entries and drops any pending feedback/mispredict pulse.
- Resolve sampled at edge t; feedback_enable, mispredict, redirect_pc and feedback_* are valid for exactly the cycle after t (registered, latency 1).
- feedback_enable and mispredict are 0 in every other cycle.
- full and empty reflect count after edge t, with no extra latency.
- Back-to-back resolves give back-to-back feedback_enable pulses.
- A pushed entry is resolvable in the cycle after its push edge. No same-cycle push-to-resolve bypass.

## Configuration
- BRANCH_STATS_EN defined:
  - stat_branches increments on every accepted resolve;
  - stat_mispredicts increments on every mispredict;
  - both counters saturate at 2^32-1 and reset to 0.
- BRANCH_STATS_EN not defined: counter logic is omitted and both outputs are tied to 0.

## Test plan
- Reset, push pc=0x100 opinion=1 taken=1 addr=0x200, resolve taken=1 target=0x200 -> next cycle feedback_enable=1, feedback_current_pc=0x100, feedback_branch_addr=0x200, mispredict=0, empty=1.
- Push pc=0x40 opinion=0, resolve taken=1 target=0x80 -> mispredict=1, redirect_pc=0x80. Push pc=0x40 opinion=0, resolve taken=0 -> mispredict=0.
- Fill 4 entries (DEPTH_LOG=2) -> full=1. Fifth push alone is dropped. Push plus non-mispredicting resolve in the same cycle -> accepted, full stays 1.
- Three entries queued, resolve oldest with mispredict, push in same cycle -> empty=1 next cycle; later resolve sets underflow=1 with no feedback_enable.
- Pointer wrap: 10 push/resolve pairs without mispredict -> feedback_current_pc order matches push order. With BRANCH_STATS_EN: stat_branches=10, stat_mispredicts=0.
- Assert reset with 2 entries and a pending resolve -> next cycle empty=1, feedback_enable=0, mispredict=0.
